// File: rtl/cpu_datapath_pkg.sv
// rtl/cpu_datapath_pkg.sv - shared widths, IR field positions and constant helpers
package cpu_datapath_pkg;

    localparam int WORD_W  = 32;
    localparam int NREG    = 16;
    localparam int FIELD_W = 4;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;
    localparam int C_W     = 19;
    localparam int PC_INC  = 4;

    function automatic logic [WORD_W-1:0] sign_ext_c(input logic [C_W-1:0] c);
        return {{(WORD_W-C_W){c[C_W-1]}}, c};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU, A from Y and B from the bus, first strobe wins
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    input  logic                inc_pc,
    input  logic                add_op,
    input  logic                sub_op,
    input  logic                and_op,
    input  logic                or_op,
    input  logic                shr_op,
    input  logic                shl_op,
    input  logic                ror_op,
    input  logic                rol_op,
    input  logic                neg_op,
    input  logic                not_op,
    output logic [2*WORD_W-1:0] alu_out
);

    logic [4:0]        sh;
    logic [5:0]        sh_inv;
    logic [WORD_W-1:0] res;

    assign sh     = b[4:0];
    // a shift by the full width yields zero, so a rotate by 0 returns a unchanged
    assign sh_inv = 6'd32 - {1'b0, sh};

    always_comb begin
        res = '0;
        if (inc_pc)      res = b + WORD_W'(PC_INC);
        else if (add_op) res = a + b;
        else if (sub_op) res = a - b;
        else if (and_op) res = a & b;
        else if (or_op)  res = a | b;
        else if (shr_op) res = a >> sh;
        else if (shl_op) res = a << sh;
        else if (ror_op) res = (a >> sh) | (a << sh_inv);
        else if (rol_op) res = (a << sh) | (a >> sh_inv);
        else if (neg_op) res = '0 - b;
        else if (not_op) res = ~b;
    end

    assign alu_out = {{WORD_W{1'b0}}, res};

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - single-bus 32-bit datapath with register file, bus mux and ALU
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin,
    input  logic        Gra, Grb, Grc,
    input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    input  logic        read,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [31:0] PC, IR, MAR, MDR, Hi, Lo,
    output logic [31:0] bus_mux_out,
    output logic [31:0] C_sign_ext,
    output logic [63:0] Z, ALUout,
    output logic [15:0] Rins, Routs
);

    logic [WORD_W-1:0]   gpr [NREG];
    logic [WORD_W-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [2*WORD_W-1:0] z_q;
    logic [FIELD_W-1:0]  sel;
    logic [NREG-1:0]     dec;
    logic [WORD_W-1:0]   bus;

    assign sel = ({FIELD_W{Gra}} & ir_q[RA_MSB -: FIELD_W])
               | ({FIELD_W{Grb}} & ir_q[RB_MSB -: FIELD_W])
               | ({FIELD_W{Grc}} & ir_q[RC_MSB -: FIELD_W]);
    assign dec   = NREG'(1) << sel;
    assign Rins  = dec & {NREG{Rin}};
    assign Routs = dec & {NREG{Rout | BAout}};

    assign C_sign_ext = sign_ext_c(ir_q[C_W-1:0]);

    always_comb begin
        bus = '0;
        if (|Routs) begin
            for (int i = 0; i < NREG; i++)
                if (Routs[i]) bus = gpr[i];
            // base-address addressing treats R0 as a literal zero
            if (Routs[0] && BAout) bus = '0;
        end
        else if (PCout)   bus = pc_q;
        else if (MDRout)  bus = mdr_q;
        else if (Zlowout) bus = z_q[WORD_W-1:0];
        else if (Cout)    bus = C_sign_ext;
    end

    cpu_alu u_alu (
        .a       (y_q),
        .b       (bus),
        .inc_pc  (IncPC),
        .add_op  (ADD),
        .sub_op  (SUB),
        .and_op  (AND),
        .or_op   (OR),
        .shr_op  (SHR),
        .shl_op  (SHL),
        .ror_op  (ROR),
        .rol_op  (ROL),
        .neg_op  (NEG),
        .not_op  (NOT),
        .alu_out (ALUout)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (Rins[i]) gpr[i] <= bus;
            if (PCin)  pc_q  <= bus;
            if (IRin)  ir_q  <= bus;
            if (MARin) mar_q <= bus;
            if (Yin)   y_q   <= bus;
            if (MDRin) mdr_q <= read ? Mdatain : bus;
            if (Zin)   z_q   <= ALUout;
        end
    end

    assign bus_mux_out = bus;
    assign PC  = pc_q;
    assign IR  = ir_q;
    assign MAR = mar_q;
    assign MDR = mdr_q;
    assign Z   = z_q;
    assign Hi  = '0;
    assign Lo  = '0;

    assign R0  = gpr[0];  assign R1  = gpr[1];  assign R2  = gpr[2];  assign R3  = gpr[3];
    assign R4  = gpr[4];  assign R5  = gpr[5];  assign R6  = gpr[6];  assign R7  = gpr[7];
    assign R8  = gpr[8];  assign R9  = gpr[9];  assign R10 = gpr[10]; assign R11 = gpr[11];
    assign R12 = gpr[12]; assign R13 = gpr[13]; assign R14 = gpr[14]; assign R15 = gpr[15];

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - directed and randomized checks of cpu_datapath against a behavioural model
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        clear;
    logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin;
    logic        Gra, Grb, Grc;
    logic        IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic        read;
    logic [31:0] Mdatain;
    logic [31:0] dut_r [16];
    logic [31:0] PC, IR, MAR, MDR, Hi, Lo, bus_mux_out, C_sign_ext;
    logic [63:0] Z, ALUout;
    logic [15:0] Rins, Routs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .clear(clear),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .read(read), .Mdatain(Mdatain),
        .R0(dut_r[0]), .R1(dut_r[1]), .R2(dut_r[2]), .R3(dut_r[3]),
        .R4(dut_r[4]), .R5(dut_r[5]), .R6(dut_r[6]), .R7(dut_r[7]),
        .R8(dut_r[8]), .R9(dut_r[9]), .R10(dut_r[10]), .R11(dut_r[11]),
        .R12(dut_r[12]), .R13(dut_r[13]), .R14(dut_r[14]), .R15(dut_r[15]),
        .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR), .Hi(Hi), .Lo(Lo),
        .bus_mux_out(bus_mux_out), .C_sign_ext(C_sign_ext),
        .Z(Z), .ALUout(ALUout), .Rins(Rins), .Routs(Routs)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;
    bit          mvalid = 1'b0;

    function automatic int m_sel();
        int s = 0;
        if (Gra) s = s | int'(m_ir[26:23]);
        if (Grb) s = s | int'(m_ir[22:19]);
        if (Grc) s = s | int'(m_ir[18:15]);
        return s;
    endfunction

    function automatic logic [31:0] m_const();
        return {{13{m_ir[18]}}, m_ir[18:0]};
    endfunction

    function automatic logic [31:0] exp_bus();
        int s = m_sel();
        if (Rout || BAout) return (BAout && s == 0) ? 32'h0 : m_r[s];
        if (PCout)   return m_pc;
        if (MDRout)  return m_mdr;
        if (Zlowout) return m_z[31:0];
        if (Cout)    return m_const();
        return 32'h0;
    endfunction

    function automatic logic [63:0] exp_alu();
        logic [31:0] a = m_y;
        logic [31:0] b = exp_bus();
        logic [31:0] r = 32'h0;
        int n = int'(b % 32);
        if (IncPC)    r = b + 4;
        else if (ADD) r = a + b;
        else if (SUB) r = a - b;
        else if (AND) r = a & b;
        else if (OR)  r = a | b;
        else if (SHR) r = a / (32'h1 << n);
        else if (SHL) r = a * (32'h1 << n);
        else if (ROR) begin
            r = a;
            for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
        end
        else if (ROL) begin
            r = a;
            for (int k = 0; k < n; k++) r = {r[30:0], r[31]};
        end
        else if (NEG) r = 32'h0 - b;
        else if (NOT) r = 32'hFFFFFFFF ^ b;
        return {32'h0, r};
    endfunction

    function automatic logic [15:0] exp_dec(input logic en);
        return en ? (16'h1 << m_sel()) : 16'h0;
    endfunction

    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] <= 32'h0;
            m_pc <= 0; m_ir <= 0; m_mar <= 0; m_mdr <= 0; m_y <= 0; m_z <= 0;
            mvalid <= 1'b1;
        end else if (mvalid) begin
            for (int i = 0; i < 16; i++)
                if (Rin && m_sel() == i) m_r[i] <= exp_bus();
            if (PCin)  m_pc  <= exp_bus();
            if (IRin)  m_ir  <= exp_bus();
            if (MARin) m_mar <= exp_bus();
            if (Yin)   m_y   <= exp_bus();
            if (MDRin) m_mdr <= read ? Mdatain : exp_bus();
            if (Zin)   m_z   <= exp_alu();
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), {32'h0, dut_r[i]}, {32'h0, m_r[i]});
            chk("PC", {32'h0, PC}, {32'h0, m_pc});
            chk("IR", {32'h0, IR}, {32'h0, m_ir});
            chk("MAR", {32'h0, MAR}, {32'h0, m_mar});
            chk("MDR", {32'h0, MDR}, {32'h0, m_mdr});
            chk("Hi", {32'h0, Hi}, 64'h0);
            chk("Lo", {32'h0, Lo}, 64'h0);
            chk("Z", Z, m_z);
            chk("bus", {32'h0, bus_mux_out}, {32'h0, exp_bus()});
            chk("C_sign_ext", {32'h0, C_sign_ext}, {32'h0, m_const()});
            chk("ALUout", ALUout, exp_alu());
            chk("Rins", {48'h0, Rins}, {48'h0, exp_dec(Rin)});
            chk("Routs", {48'h0, Routs}, {48'h0, exp_dec(Rout | BAout)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, Zin, Rin} = '0;
        {Gra, Grb, Grc} = '0;
        {IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
        read = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; read = 1; MDRin = 1;
        tick();
    endtask

    task automatic alu_case(input int op, input bit drive_mdr, input logic [31:0] exp, input string nm);
        MDRout = drive_mdr;
        case (op)
            0: ADD = 1;  1: SUB = 1;  2: SHR = 1;  3: ROL = 1;
            4: NEG = 1;  5: NOT = 1;  6: AND = 1;  7: OR  = 1;
            8: SHL = 1;  9: ROR = 1;  default: IncPC = 1;
        endcase
        #1 chk(nm, ALUout, {32'h0, exp});
        tick();
    endtask

    initial begin
        idle();
        Mdatain = 0;
        clear = 1;
        @(posedge clk);
        @(posedge clk);
        #2 clear = 0;
        chk("rst_PC", {32'h0, PC}, 64'h0);
        chk("rst_IR", {32'h0, IR}, 64'h0);
        chk("rst_Z", Z, 64'h0);
        chk("rst_R7", {32'h0, dut_r[7]}, 64'h0);
        chk("rst_bus", {32'h0, bus_mux_out}, 64'h0);
        chk("rst_Rins", {48'h0, Rins}, 64'h0);
        chk("rst_Routs", {48'h0, Routs}, 64'h0);

        load_mdr(32'h0);
        MDRout = 1; PCin = 1; tick();
        chk("fetch_PC0", {32'h0, PC}, 64'h0);
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        chk("fetch_MAR0", {32'h0, MAR}, 64'h0);
        chk("fetch_Z4", Z, 64'h4);
        Zlowout = 1; PCin = 1; tick();
        chk("fetch_PC4", {32'h0, PC}, 64'h4);

        load_mdr(32'h01000085);
        MDRout = 1; IRin = 1; tick();
        chk("ir_load", {32'h0, IR}, 64'h01000085);
        chk("c_ext", {32'h0, C_sign_ext}, 64'h85);
        Grb = 1; BAout = 1; Yin = 1;
        #1 chk("ba_r0_zero", {32'h0, bus_mux_out}, 64'h0);
        tick();
        Cout = 1; ADD = 1; Zin = 1;
        #1 chk("c_add_alu", ALUout, 64'h85);
        tick();
        chk("c_add_z", Z, 64'h85);
        Zlowout = 1; MARin = 1; tick();
        chk("mar_85", {32'h0, MAR}, 64'h85);
        load_mdr(32'h2);
        MDRout = 1; Gra = 1; Rin = 1;
        #1 chk("rins_r2", {48'h0, Rins}, 64'h0004);
        tick();
        chk("r2_load", {32'h0, dut_r[2]}, 64'h2);

        load_mdr(32'hF0000001);
        MDRout = 1; Yin = 1; tick();
        load_mdr(32'h4);
        alu_case(0, 1, 32'hF0000005, "alu_add");
        alu_case(1, 1, 32'hEFFFFFFD, "alu_sub");
        alu_case(2, 1, 32'h0F000000, "alu_shr");
        alu_case(3, 1, 32'h0000001F, "alu_rol");
        alu_case(4, 1, 32'hFFFFFFFC, "alu_neg");
        alu_case(5, 1, 32'hFFFFFFFB, "alu_not");
        alu_case(6, 1, 32'h00000000, "alu_and");
        alu_case(7, 1, 32'hF0000005, "alu_or");
        alu_case(8, 1, 32'h00000010, "alu_shl");
        alu_case(9, 1, 32'h1F000000, "alu_ror");
        alu_case(10, 1, 32'h00000008, "alu_inc");
        alu_case(2, 0, 32'hF0000001, "alu_shr0");
        alu_case(3, 0, 32'hF0000001, "alu_rol0");

        load_mdr(32'h7);
        MDRout = 1; Grb = 1; Rin = 1; tick();
        chk("r0_load", {32'h0, dut_r[0]}, 64'h7);
        Grb = 1; Rout = 1;
        #1 chk("rout_r0", {32'h0, bus_mux_out}, 64'h7);
        Rout = 0; BAout = 1;
        #1 chk("baout_r0", {32'h0, bus_mux_out}, 64'h0);
        tick();

        load_mdr(32'h9);
        MDRout = 1; PCin = 1; clear = 1;
        #1 chk("clr_bus9", {32'h0, bus_mux_out}, 64'h9);
        tick();
        clear = 0;
        chk("clr_pc", {32'h0, PC}, 64'h0);

        for (int c = 0; c < 3000; c++) begin
            PCout   = ($urandom_range(0, 3) == 0);
            Zlowout = ($urandom_range(0, 3) == 0);
            MDRout  = ($urandom_range(0, 3) == 0);
            Cout    = ($urandom_range(0, 3) == 0);
            BAout   = ($urandom_range(0, 5) == 0);
            Rout    = ($urandom_range(0, 3) == 0);
            PCin    = ($urandom_range(0, 2) == 0);
            MARin   = ($urandom_range(0, 2) == 0);
            MDRin   = ($urandom_range(0, 1) == 0);
            IRin    = ($urandom_range(0, 3) == 0);
            Yin     = ($urandom_range(0, 2) == 0);
            Zin     = ($urandom_range(0, 2) == 0);
            Rin     = ($urandom_range(0, 1) == 0);
            Gra     = ($urandom_range(0, 2) == 0);
            Grb     = ($urandom_range(0, 2) == 0);
            Grc     = ($urandom_range(0, 2) == 0);
            IncPC   = ($urandom_range(0, 9) == 0);
            ADD     = ($urandom_range(0, 5) == 0);
            SUB     = ($urandom_range(0, 5) == 0);
            AND     = ($urandom_range(0, 5) == 0);
            OR      = ($urandom_range(0, 5) == 0);
            SHR     = ($urandom_range(0, 5) == 0);
            SHL     = ($urandom_range(0, 5) == 0);
            ROR     = ($urandom_range(0, 5) == 0);
            ROL     = ($urandom_range(0, 5) == 0);
            NEG     = ($urandom_range(0, 5) == 0);
            NOT     = ($urandom_range(0, 5) == 0);
            read    = ($urandom_range(0, 1) == 0);
            Mdatain = $urandom;
            clear   = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #2;
        end
        idle();
        clear = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Single-bus 32-bit CPU datapath: 16 general registers R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, Hi, Lo, a combinational ALU, IR-field register-select logic and a sign-extended constant source.
- The external control sequencer drives one-hot strobes each clock.
- All internal registers and key nets are exported for debug and verification.

Parameters:
- none (width 32 and 16 registers fixed)

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- PCout, Zlowout, MDRout, Cout, BAout, Rout  in  1 each  bus-source enables
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin  in  1 each  register load enables
- Gra, Grb, Grc  in  1 each  select IR field ra / rb / rc
- IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU operation strobes
- read  in  1  MDR loads from Mdatain instead of bus
- Mdatain  in  32  memory read data
- R0..R15, PC, IR, MAR, MDR, Hi, Lo  out  32 each  register contents
- bus_mux_out  out  32  internal bus value
- C_sign_ext  out  32  IR[18:0] sign-extended
- Z, ALUout  out  64 each  Z register / ALU combinational result
- Rins, Routs  out  16 each  decoded per-register load / drive enables

Behaviour:
- All registers update on rising clk.
- clear=1 at an edge forces every register (R0–R15, PC, IR, MAR, MDR, Y, Z, Hi, Lo) to 0 and overrides all loads.
- Field select:
  - sel = (Gra?IR[26:23]:0) | (Grb?IR[22:19]:0) | (Grc?IR[18:15]:0).
  - dec = 4-to-16 one-hot of sel.
  - Rins = dec & {16{Rin}}.
  - Routs = dec & {16{Rout|BAout}}.
- Bus mux (combinational), first match wins:
  - Routs[i] → Ri, except R0 when BAout=1 drives 32'h0 (base-address zero rule).
  - PCout → PC.
  - MDRout → MDR.
  - Zlowout → Z[31:0].
  - Cout → C_sign_ext.
  - None asserted → 0.
- Register loads:
  - Ri <= bus when Rins[i].
  - PC, IR, MAR, Y <= bus on their *in strobe.
  - MDR <= read?Mdatain:bus when MDRin.
  - Z <= ALUout when Zin.
- Hi and Lo have no load path in this revision; they hold 0.
- ALU: A = Y, B = bus, result 64-bit. First asserted strobe wins:
  - IncPC: B+4.
  - ADD: A+B.
  - SUB: A−B.
  - AND, OR.
  - SHR: logical, A>>B[4:0].
  - SHL: A<<B[4:0].
  - ROR, ROL: rotate A by B[4:0].
  - NEG: 0−B.
  - NOT: ~B.
  - No strobe asserted → 0.
- ALU result in [31:0], [63:32] = 0 for every op. Arithmetic wraps modulo 2^32. Shift amount 0 returns A unchanged.
- Simultaneous load strobes are all honoured in the same edge.
- Reading and writing the same register in one cycle returns the old value on the bus; the new value appears after the edge.
- clear asserted mid-sequence discards any pending loads that edge.
- Latency: a source enabled in cycle n is captured by the destination at the end of cycle n.

Decomposition:
- Shared package `cpu_datapath_pkg`: WORD_W=32, NREG=16, IR field bit positions (RA_MSB=26, RB_MSB=22, RC_MSB=18, C_W=19), increment constant PC_INC=4.
- One sub-module `cpu_alu`: operand A, operand B, strobes in; ALUout out.
- Register file, select/encode and bus mux stay in the top module.

Test Plan:
- Clear then all strobes low → every register, Z and bus_mux_out read 0; Rins/Routs = 0.
- Mdatain=0, read+MDRin one cycle, then MDRout+PCin → PC=0. Then PCout+MARin+IncPC+Zin → MAR=0, Z=4. Then Zlowout+PCin → PC=4.
- Mdatain=32'h01000085, read+MDRin, then MDRout+IRin → IR=32'h01000085, C_sign_ext=32'h85.
  - Grb+BAout+Yin → Y=0 (R0 forced to 0).
  - Cout+ADD+Zin → Z=32'h85.
  - Zlowout+MARin → MAR=32'h85.
  - Mdatain=2 with read+MDRin, then MDRout+Gra+Rin → Rins=16'h0004, R2=2.
- ALU sweep with Y=32'hF0000001, bus=4:
  - ADD → 32'hF0000005.
  - SUB → 32'hEFFFFFFD.
  - SHR → 32'h0F000000.
  - ROL → 32'h0000001F.
  - NEG → 32'hFFFFFFFC.
  - NOT → 32'hFFFFFFFB.
  - Z[63:32]=0 throughout.
- Rout with R0 selected and R0 loaded 7 → bus=7; same with BAout → bus=0.
- clear asserted in the same cycle as PCin with bus=9 → PC=0.
